// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the fetch PC and issues one request at a time
//   to a variable-latency instruction memory (req held until a 1-cycle ack).
//   Returned words go into a small circular prefetch queue whose head is shown
//   to decode as {instr, pc, pc+2} with a valid/ready handshake. Redirects
//   flush the queue and restart fetch. Fetch stops after an HLT word (top
//   nibble 4'hF) until the next redirect.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-low reset
//   imem_req_o     request to instruction memory, held until ack
//   imem_addr_o    request address, stable while imem_req_o=1
//   imem_ack_i     1-cycle pulse, imem_rdata_i valid in that cycle
//   imem_rdata_i   returned instruction word
//   redirect_i     taken branch/jump target presented this cycle
//   redirect_pc_i  new fetch address (bit 0 forced to 0)
//   id_ready_i     decode consumes the head entry when if_valid_o=1
//   if_valid_o     prefetch queue non-empty
//   if_instr_o     head instruction (0 when empty)
//   if_pc_o        address of head instruction (0 when empty)
//   if_pc_plus2_o  if_pc_o + 2, wrapping (0 when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                AWIDTH   = 16,
  parameter int                DWIDTH   = 16,
  parameter int                QDEPTH   = 2,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              id_ready_i,
  output logic              if_valid_o,
  output logic [DWIDTH-1:0] if_instr_o,
  output logic [AWIDTH-1:0] if_pc_o,
  output logic [AWIDTH-1:0] if_pc_plus2_o
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    S_FETCH,   // may issue a request
    S_WAIT,    // one request outstanding
    S_HALTED   // HLT seen, no issue until redirect
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic [AWIDTH-1:0] addr_q;
  logic [AWIDTH-1:0] fetch_pc_q;
  logic              discard_q;   // outstanding request belongs to a stale path
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;

  logic [DWIDTH-1:0] instr_mem [QDEPTH];
  logic [AWIDTH-1:0] pc_mem    [QDEPTH];

  logic [AWIDTH-1:0] target_pc;
  logic              push;
  logic              pop;
  logic              is_hlt;
  logic              can_issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign target_pc = redirect_pc_i & ~AWIDTH'(1);
  // An ack coinciding with a redirect, or answering a pre-redirect request,
  // carries wrong-path data and is dropped.
  assign push      = (state_q == S_WAIT) && imem_ack_i && !discard_q && !redirect_i;
  assign pop       = if_valid_o && id_ready_i && !redirect_i;
  assign is_hlt    = (imem_rdata_i[DWIDTH-1 -: 4] == 4'hF);
  // Only issued from S_FETCH, where nothing is outstanding, so the queue count
  // alone bounds count + outstanding.
  assign can_issue = (count_q < CW'(QDEPTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_FETCH;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      // Queue bookkeeping; a redirect flushes and overrides any pop.
      if (redirect_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= ptr_inc(tail_q);
        if (pop)  head_q <= ptr_inc(head_q);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: ;
        endcase
      end

      case (state_q)
        S_FETCH, S_HALTED: begin
          if (redirect_i) begin
            // Queue is flushed this edge, so a request can go out at once.
            req_q      <= 1'b1;
            addr_q     <= target_pc;
            fetch_pc_q <= target_pc;
            state_q    <= S_WAIT;
          end else if (state_q == S_FETCH && can_issue) begin
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack_i) begin
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            state_q   <= (push && is_hlt) ? S_HALTED : S_FETCH;
            if (redirect_i)  fetch_pc_q <= target_pc;
            else if (push)   fetch_pc_q <= addr_q + AWIDTH'(2);
          end else if (redirect_i) begin
            // Request stays on the bus until acked; remember to drop its data.
            discard_q  <= 1'b1;
            fetch_pc_q <= target_pc;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // NOTE: queue storage has no reset; entries are only visible through the
  // reset count, so stale contents can never reach decode.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[tail_q] <= imem_rdata_i;
      pc_mem[tail_q]    <= addr_q;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign if_valid_o    = (count_q != '0);
  assign if_instr_o    = if_valid_o ? instr_mem[head_q] : '0;
  assign if_pc_o       = if_valid_o ? pc_mem[head_q] : '0;
  assign if_pc_plus2_o = if_valid_o ? pc_mem[head_q] + AWIDTH'(2) : '0;

endmodule
